// File: rtl/adder_share_arb_if.sv
// Handshake bundle between the requesters / result consumer and the shared
// adder arbiter (adder_share_arb).
//
// Handshake semantics (both channels): a beat transfers on a rising clk edge
// where valid and ready are both 1. A requester may raise or drop req_valid
// freely; its operands are consumed only on the edge where it is granted
// (req_ready bit set). The result channel holds resp_* stable while
// resp_valid=1 and resp_ready=0.
interface adder_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_sub;
    logic               resp_valid;
    logic               resp_ready;
    logic [31:0]        resp_sum;
    logic               resp_cout;
    logic               resp_ovf;
    logic [IDW-1:0]     resp_id;

    // Requester/consumer side
    modport master (
        output req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, resp_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_cout, resp_ovf, resp_id
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among NREQ
// requesters. The winner's operands go through the adder in the grant cycle
// and the result lands in a single-entry output register tagged with the
// requester id. A drain and a new accept may happen on the same edge, so the
// block sustains one result per cycle.
//
// Optional feature: define ADDER_SHARE_SUB_EN to honour req_sub (a - b as
// a + ~b + 1). Without it req_sub is ignored but the port stays in place.
// IDW must satisfy 2**IDW >= NREQ.

// 32-bit adder built from 4-bit lookahead groups chained group to group.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry lookahead inside each 4-bit group; group carry feeds the next group.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);
    logic [IDW-1:0] rr_ptr;
    logic           out_valid;
    logic [31:0]    out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic [IDW-1:0] out_id;

    logic           slot_free;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_onehot;

    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic           op_sub;
    logic           op_cin;
    logic [31:0]    b_eff;
    logic           cin_eff;
    logic [31:0]    add_sum;
    logic           add_cout;
    logic           add_ovf;

    // The output slot can take a new result if empty or being drained now.
    assign slot_free = !out_valid || bus.resp_ready;

    // First valid requester at or after rr_ptr (modulo NREQ) wins the slot.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && rst_n && slot_free && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    assign gnt_onehot    = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign bus.req_ready = gnt_onehot;

    // Winner's operands feed the single shared adder.
    assign op_a   = bus.req_a[32*int'(gnt_idx) +: 32];
    assign op_b   = bus.req_b[32*int'(gnt_idx) +: 32];
    assign op_cin = bus.req_cin[gnt_idx];
    assign op_sub = bus.req_sub[gnt_idx];

`ifdef ADDER_SHARE_SUB_EN
    // Subtract as a + ~b + 1; cout then reads as not-borrow.
    assign b_eff   = op_sub ? ~op_b : op_b;
    assign cin_eff = op_sub ? 1'b1 : op_cin;
`else
    logic unused_sub;
    assign unused_sub = op_sub ^ (^bus.req_sub);
    assign b_eff      = op_b;
    assign cin_eff    = op_cin;
`endif

    cla32 u_cla32 (
        .a    (op_a),
        .b    (b_eff),
        .cin  (cin_eff),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = (op_a[31] == b_eff[31]) && (add_sum[31] != op_a[31]);

    // Output register and round-robin pointer: load on grant, clear on bare drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_cout  <= add_cout;
            out_ovf   <= add_ovf;
            out_id    <= gnt_idx;
            rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (out_valid && bus.resp_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.resp_valid = out_valid;
    assign bus.resp_sum   = out_sum;
    assign bus.resp_cout  = out_cout;
    assign bus.resp_ovf   = out_ovf;
    assign bus.resp_id    = out_id;
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model and a
// result queue.
module tb_adder_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 32 + 1 + 1 + IDW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- stimulus state ----------------
    logic [NREQ-1:0] drv_valid;
    logic [31:0]     drv_a [NREQ];
    logic [31:0]     drv_b [NREQ];
    logic [NREQ-1:0] drv_cin;
    logic [NREQ-1:0] drv_sub;
    logic [NREQ-1:0] seen_ready;

    // ---------------- model / scoreboard ----------------
    logic           m_valid;
    logic [31:0]    m_sum;
    logic           m_cout;
    logic           m_ovf;
    logic [IDW-1:0] m_id;
    int             m_ptr;
    logic [W-1:0]   exp_q[$];

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check req_ready, advance model, check outputs.
    task automatic step(input logic rn, input logic rr);
        int g;
        int idx;
        logic [NREQ-1:0] exp_ready;
        logic [32:0] full;
        logic [31:0] be;
        logic        ce;
        logic [W-1:0] e;

        rst_n          = rn;
        bus.resp_ready = rr;
        bus.req_valid  = drv_valid;
        bus.req_cin    = drv_cin;
        bus.req_sub    = drv_sub;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = drv_a[i];
            bus.req_b[32*i +: 32] = drv_b[i];
        end
        #1;

        g = -1;
        if (rn && (!m_valid || rr)) begin
            for (int j = 0; j < NREQ; j++) begin
                idx = (m_ptr + j) % NREQ;
                if (g < 0 && drv_valid[idx]) g = idx;
            end
        end
        exp_ready  = (g >= 0) ? (NREQ'(1) << g) : '0;
        seen_ready = bus.req_ready;
        chk("req_ready", 64'(seen_ready), 64'(exp_ready));

        if (rn && m_valid && rr) begin
            if (exp_q.size() == 0) begin
                chk("drain_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("drain_data", 64'({bus.resp_id, bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'(e));
            end
        end

        if (!rn) begin
            m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = '0;
            m_ptr = 0;
            exp_q.delete();
        end else if (g >= 0) begin
            be = drv_b[g];
            ce = drv_cin[g];
`ifdef ADDER_SHARE_SUB_EN
            if (drv_sub[g]) begin
                be = ~drv_b[g];
                ce = 1'b1;
            end
`endif
            full    = {1'b0, drv_a[g]} + {1'b0, be} + 33'(ce);
            m_valid = 1'b1;
            m_sum   = full[31:0];
            m_cout  = full[32];
            m_ovf   = (drv_a[g][31] == be[31]) && (full[31] != drv_a[g][31]);
            m_id    = IDW'(g);
            m_ptr   = (g + 1) % NREQ;
            exp_q.push_back({m_id, m_ovf, m_cout, m_sum});
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
        chk("resp_sum",   64'(bus.resp_sum),   64'(m_sum));
        chk("resp_cout",  64'(bus.resp_cout),  64'(m_cout));
        chk("resp_ovf",   64'(bus.resp_ovf),   64'(m_ovf));
        chk("resp_id",    64'(bus.resp_id),    64'(m_id));
        @(negedge clk);
    endtask

    task automatic clear_drive();
        drv_valid = '0; drv_cin = '0; drv_sub = '0;
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: rand_op = 32'hFFFF_FFFF;
            1: rand_op = 32'h7FFF_FFFF;
            2: rand_op = 32'h8000_0000;
            3: rand_op = 32'h0000_0000;
            default: rand_op = $urandom();
        endcase
    endfunction

    logic [NREQ-1:0] rr_exp [5];
    logic [31:0]     held_sum;

    initial begin
        vectors = 0; miscompares = 0;
        m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = '0; m_ptr = 0;
        rst_n = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.req_sub = '0;
        clear_drive();
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset_sum",   64'(bus.resp_sum),   64'd0);

        // Single request: 5 + 3 + 1
        drv_valid = 4'b0001; drv_a[0] = 32'd5; drv_b[0] = 32'd3; drv_cin = 4'b0001;
        step(1'b1, 1'b1);
        chk("single_ready", 64'(seen_ready), 64'(4'b0001));
        chk("single_valid", 64'(bus.resp_valid), 64'd1);
        chk("single_sum",   64'(bus.resp_sum),   64'h9);
        chk("single_cout",  64'(bus.resp_cout),  64'd0);
        chk("single_id",    64'(bus.resp_id),    64'd0);
        clear_drive();
        step(1'b1, 1'b1);
        chk("drained_valid", 64'(bus.resp_valid), 64'd0);

        // Round robin from reset: 0,1,2,3,0 at full throughput
        step(1'b0, 1'b1);
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        drv_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i] = 32'(i * 16); drv_b[i] = 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk("rr_ready", 64'(seen_ready), 64'(rr_exp[i]));
            chk("rr_valid", 64'(bus.resp_valid), 64'd1);
        end

        // Backpressure: last grant was 0, so requester 1 is next
        held_sum = bus.resp_sum;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("bp_ready", 64'(seen_ready), 64'd0);
            chk("bp_sum",   64'(bus.resp_sum), 64'(held_sum));
        end
        step(1'b1, 1'b1);
        chk("bp_release_ready", 64'(seen_ready), 64'(4'b0010));

        // Carry / overflow boundaries
        clear_drive();
        drv_valid = 4'b0100; drv_a[2] = 32'h7FFF_FFFF; drv_b[2] = 32'h0000_0001;
        step(1'b1, 1'b1);
        chk("ovf_sum",  64'(bus.resp_sum),  64'h8000_0000);
        chk("ovf_cout", 64'(bus.resp_cout), 64'd0);
        chk("ovf_ovf",  64'(bus.resp_ovf),  64'd1);
        chk("ovf_id",   64'(bus.resp_id),   64'd2);
        clear_drive();
        drv_valid = 4'b1000; drv_a[3] = 32'hFFFF_FFFF; drv_b[3] = 32'h0000_0001;
        step(1'b1, 1'b1);
        chk("carry_sum",  64'(bus.resp_sum),  64'h0);
        chk("carry_cout", 64'(bus.resp_cout), 64'd1);
        chk("carry_ovf",  64'(bus.resp_ovf),  64'd0);

        // Mid-operation reset with result pending and requests waiting
        drv_valid = 4'b1111;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("midrst_ready", 64'(seen_ready), 64'd0);
        chk("midrst_valid", 64'(bus.resp_valid), 64'd0);
        step(1'b1, 1'b1);
        chk("postrst_ready", 64'(seen_ready), 64'(4'b0001));

        // Subtract request: 5 - 7 with the feature, 5 + 7 without it
        clear_drive();
        drv_valid = 4'b0010; drv_a[1] = 32'd5; drv_b[1] = 32'd7; drv_sub = 4'b0010;
        step(1'b1, 1'b1);
`ifdef ADDER_SHARE_SUB_EN
        chk("sub_sum",  64'(bus.resp_sum),  64'hFFFF_FFFE);
        chk("sub_cout", 64'(bus.resp_cout), 64'd0);
`else
        chk("sub_sum",  64'(bus.resp_sum),  64'h0000_000C);
        chk("sub_cout", 64'(bus.resp_cout), 64'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drv_valid = NREQ'($urandom());
            drv_cin   = NREQ'($urandom());
            drv_sub   = NREQ'($urandom());
            for (int i = 0; i < NREQ; i++) begin
                drv_a[i] = rand_op();
                drv_b[i] = rand_op();
            end
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one cla32 adder instance among NREQ requesters (ALU, AGU, branch-target and PC-increment paths in the mini core).
- Each requester presents operands with a valid/ready handshake.
- The winner's operands pass through the shared adder in the grant cycle; the result is held in a single-entry output register tagged with the requester id.
- The block provides backpressure and fair arbitration with no starvation.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  32*NREQ  operand A, requester i at bits [32*i +: 32].
- req_b  input  32*NREQ  operand B, same packing.
- req_cin  input  NREQ  carry-in per requester.
- req_sub  input  NREQ  subtract request; used only with the optional feature.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_sum  output  32  registered sum.
- resp_cout  output  1  registered carry-out.
- resp_ovf  output  1  registered signed overflow: (a[31]==b_eff[31]) && (sum[31]!=a[31]).
- resp_id  output  IDW  index of the requester that produced the result.

Behaviour:
- Reset: clk and rst_n only; rst_n is synchronous, active-low. While rst_n=0 at a rising edge:
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, resp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 combinationally whenever rst_n=0.
- Slot free condition: slot_free = !resp_valid || resp_ready (output register empty, or being drained this cycle).
- Grant, combinational:
  - When slot_free, grant the first requester with req_valid=1, searching from rr_ptr upward modulo NREQ.
  - req_ready[g]=1 only for the granted index g; all other bits are 0.
  - No grant when slot_free=0 or no valid request.
- Datapath: the winner's a, b_eff and cin are muxed into a single cla32.
  - b_eff = req_b[g] without the optional feature.
  - The adder is purely combinational; there is no other adder in the block.
- Transfer: on a rising edge with req_valid[g] && req_ready[g]:
  - resp_sum, resp_cout, resp_ovf and resp_id (= g) are loaded.
  - resp_valid is set to 1.
  - rr_ptr becomes (g+1) mod NREQ.
- Drain without refill: on resp_valid && resp_ready with no new grant, resp_valid is cleared to 0; the data registers hold their last value.
- Simultaneous drain and accept: the register is overwritten with the new result and resp_valid stays 1. This gives full throughput of one result per cycle.
- Backpressure: while resp_valid=1 and resp_ready=0:
  - All req_ready stay 0 and the output registers are stable.
  - rr_ptr does not move.
- Latency: exactly 1 cycle from the accepting edge to resp_valid=1.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Requesters may drop req_valid without a grant (no stickiness required). Once a requester is granted, its operands are consumed in that cycle.
- Reset mid-operation: a pending result is discarded (resp_valid=0) and rr_ptr returns to 0.
- Unused id values (g >= NREQ) never appear on resp_id.

Optional Feature:
- Macro: ADDER_SHARE_SUB_EN.
- Defined:
  - When req_sub[g]=1, b_eff = ~req_b[g] and the effective carry-in = 1; req_cin[g] is ignored for that request.
  - resp_cout is the not-borrow; resp_ovf uses b_eff.
- Undefined:
  - req_sub is ignored entirely.
  - b_eff = req_b[g] and carry-in = req_cin[g].
  - The port remains present so instantiations are unchanged.

Test Plan:
- Reset, then single request: req_valid=0001, a=0x0000_0005, b=0x0000_0003, cin=1, resp_ready=1 -> req_ready=0001 that cycle; next cycle resp_valid=1, resp_sum=0x0000_0009, resp_cout=0, resp_id=0.
- All four requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; resp_valid held at 1 every cycle after the first; rr_ptr wraps.
- Backpressure: result pending, resp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 and resp_sum stable for 3 cycles; on resp_ready=1, the next requester after the last grant is accepted in that same cycle.
- Carry/overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1; a=0xFFFF_FFFF, b=0x0000_0001 -> sum=0, cout=1, ovf=0.
- Mid-operation reset: rst_n=0 for one cycle while resp_valid=1 and requests pending -> resp_valid=0, req_ready=0; after release, requester 0 is granted first.
- With ADDER_SHARE_SUB_EN: req_sub=1, a=5, b=7 -> resp_sum=0xFFFF_FFFE, resp_cout=0; without the macro, same stimulus with cin=0 -> resp_sum=0x0000_000C.
